// File: rtl/ama_riscv_decode_ctrl.sv
// Decode-stage controller: 2-entry skid FIFO between fetch and decode, opcode -> imm_gen select.
// Optional perf counters enabled by AMA_RISCV_DEC_CTRL_PERF_EN.
module ama_riscv_decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_illegal,
  output logic [2:0]  ig_sel,
  output logic [24:0] ig_in,
  input  logic        flush,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
);

  // Local copies of the IG_* select encodings used by ama_riscv_imm_gen
  localparam logic [2:0] IgDisabled = 3'd0;
  localparam logic [2:0] IgIType    = 3'd1;
  localparam logic [2:0] IgSType    = 3'd2;
  localparam logic [2:0] IgBType    = 3'd3;
  localparam logic [2:0] IgJType    = 3'd4;
  localparam logic [2:0] IgUType    = 3'd5;

  localparam logic [1:0] CntEmpty = 2'd0;
  localparam logic [1:0] CntOne   = 2'd1;
  localparam logic [1:0] CntFull  = 2'd2;

  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        held_q, held_d;
  logic [31:0] inst_mem [2];
  logic [31:0] pc_mem [2];
  logic        push, pop;
  logic [2:0]  class_sel;
  logic        class_illegal;

  assign if_ready = rst_n & (cnt_q != CntFull);
  assign id_valid = (cnt_q != CntEmpty) & ~flush;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  assign id_inst  = inst_mem[rd_ptr_q];
  assign id_pc    = pc_mem[rd_ptr_q];
  assign ig_in    = id_inst[31:7];

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    held_d   = id_valid & ~id_ready;
    if (flush) begin
      cnt_d    = CntEmpty;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      held_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= CntEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      held_q   <= held_d;
    end
  end

  // Payload storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr_q] <= if_inst;
      pc_mem[wr_ptr_q]   <= if_pc;
    end
  end

  always_comb begin
    class_sel     = IgDisabled;
    class_illegal = 1'b0;
    case (id_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: class_sel = IgIType;
      7'b0100011:                         class_sel = IgSType;
      7'b1100011:                         class_sel = IgBType;
      7'b1101111:                         class_sel = IgJType;
      7'b0110111, 7'b0010111:             class_sel = IgUType;
      7'b0110011, 7'b0001111, 7'b1110011: class_sel = IgDisabled;
      default:                            class_illegal = 1'b1;
    endcase
  end

  // A held head keeps imm_gen replaying the immediate it already produced
  assign ig_sel     = (id_valid && !held_q) ? class_sel : IgDisabled;
  assign id_illegal = id_valid & class_illegal;

`ifdef AMA_RISCV_DEC_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (id_valid && !id_ready) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (!id_valid && !flush)   bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ama_riscv_decode_ctrl.sv
// Randomized + directed bench for ama_riscv_decode_ctrl against a queue-based reference model.
module tb_ama_riscv_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_illegal;
  logic [2:0]  ig_sel;
  logic [24:0] ig_in;
  logic        flush;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;

  ama_riscv_decode_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_ready        (if_ready),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_illegal      (id_illegal),
    .ig_sel          (ig_sel),
    .ig_in           (ig_in),
    .flush           (flush),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as a queue of {pc, inst}
  logic [63:0] mq[$];
  bit          m_held;
  logic [31:0] m_stall;
  logic [31:0] m_bubble;
  logic [31:0] pc_next = 32'h1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {illegal, sel} for an instruction
  function automatic logic [3:0] ref_class(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) return {1'b0, 3'd1};
    if (op == 7'h23) return {1'b0, 3'd2};
    if (op == 7'h63) return {1'b0, 3'd3};
    if (op == 7'h6F) return {1'b0, 3'd4};
    if (op == 7'h37 || op == 7'h17) return {1'b0, 3'd5};
    if (op == 7'h33 || op == 7'h0F || op == 7'h73) return {1'b0, 3'd0};
    return {1'b1, 3'd0};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [14];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F, 7'h73,
            7'h7F, 7'h00, 7'h5B};
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {$urandom_range(0, 32'h1FF_FFFF), 7'h00} | {25'd0, ops[$urandom_range(0, 13)]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_held   = 1'b0;
    m_stall  = 32'd0;
    m_bubble = 32'd0;
  endtask

  // Drive inputs now, check outputs combinationally, then advance the model by one edge
  task automatic drive_check(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
    bit          exp_valid, exp_ready;
    logic [3:0]  cls;
    logic [31:0] head_inst, head_pc;
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc_next;
    id_ready = rdy;
    flush    = fl;
    #1;
    exp_ready = (mq.size() < 2);
    exp_valid = (mq.size() > 0) && !fl;
    check_eq("if_ready", {31'd0, if_ready}, {31'd0, exp_ready});
    check_eq("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      head_inst = mq[0][31:0];
      head_pc   = mq[0][63:32];
      cls       = ref_class(head_inst);
      check_eq("id_inst", id_inst, head_inst);
      check_eq("id_pc", id_pc, head_pc);
      check_eq("ig_in", {7'd0, ig_in}, {7'd0, head_inst[31:7]});
      check_eq("id_illegal", {31'd0, id_illegal}, {31'd0, cls[3]});
      check_eq("ig_sel", {29'd0, ig_sel}, m_held ? 32'd0 : {29'd0, cls[2:0]});
    end else begin
      check_eq("ig_sel_idle", {29'd0, ig_sel}, 32'd0);
      check_eq("id_illegal_idle", {31'd0, id_illegal}, 32'd0);
    end
`ifdef AMA_RISCV_DEC_CTRL_PERF_EN
    check_eq("perf_stall", perf_stall_cnt, m_stall);
    check_eq("perf_bubble", perf_bubble_cnt, m_bubble);
`else
    check_eq("perf_stall", perf_stall_cnt, 32'd0);
    check_eq("perf_bubble", perf_bubble_cnt, 32'd0);
`endif
    if (exp_valid && !rdy) m_stall++;
    if (!exp_valid && !fl) m_bubble++;
    if (fl) begin
      mq.delete();
      m_held = 1'b0;
    end else begin
      m_held = exp_valid && !rdy;
      if (exp_valid && rdy) void'(mq.pop_front());
      if (v && exp_ready) begin
        mq.push_back({pc_next, inst});
        pc_next += 32'd4;
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
    @(negedge clk);
    drive_check(v, inst, rdy, fl);
  endtask

  task automatic check_in_reset();
    check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check_eq("rst_ig_sel", {29'd0, ig_sel}, 32'd0);
    check_eq("rst_stall", perf_stall_cnt, 32'd0);
    check_eq("rst_bubble", perf_bubble_cnt, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_inst  = 32'd0;
    if_pc    = 32'd0;
    id_ready = 1'b0;
    flush    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_in_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_check(1'b0, 32'd0, 1'b1, 1'b0);

    // Back-to-back stream: I, S, B, J, U
    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    step(1'b1, 32'h0020A223, 1'b1, 1'b0);
    step(1'b1, 32'h00208463, 1'b1, 1'b0);
    step(1'b1, 32'h0080006F, 1'b1, 1'b0);
    step(1'b1, 32'h000010B7, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Stall: head held 3 cycles while fetch keeps offering, then drain
    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    step(1'b1, 32'h0020A223, 1'b0, 1'b0);
    step(1'b1, 32'h00208463, 1'b0, 1'b0);
    step(1'b1, 32'h0080006F, 1'b0, 1'b0);
    step(1'b1, 32'h0080006F, 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with FIFO full and a simultaneous push
    step(1'b1, 32'h00100113, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Illegal and R-type
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    step(1'b1, 32'h002081B3, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with the FIFO full
    step(1'b1, 32'h00400293, 1'b0, 1'b0);
    step(1'b1, 32'h00500313, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_in_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_check(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_decode_ctrl.md
# ama_riscv_decode_ctrl

Decode-stage controller sitting between instruction fetch and the decode/execute boundary of the ama-riscv core. It buffers fetched instructions in a 2-entry skid FIFO with valid/ready handshakes on both sides, and classifies the head instruction's opcode into an immediate-generator select. It drives that select plus `inst[31:7]` into `ama_riscv_imm_gen`, forcing `IG_DISABLED` on held cycles so the generator replays its stored value. It also absorbs pipeline flushes and flags unsupported opcodes.

## Interface
- No parameters. Depth is fixed at 2; `ig_sel` encodings are the `IG_*` macros from `ama_riscv_defines.v`.
- `clk  input  1  clock`; all state updates on the rising edge.
- `rst_n  input  1  asynchronous, active-low reset`.
- `if_valid  input  1  fetch offers an instruction`.
- `if_inst  input  32  fetched instruction`.
- `if_pc  input  32  PC of fetched instruction`.
- `if_ready  output  1  FIFO can accept`.
- `id_valid  output  1  head instruction valid`.
- `id_ready  input  1  downstream accepts head`.
- `id_inst  output  32  head instruction`.
- `id_pc  output  32  head PC`.
- `id_illegal  output  1  head opcode unsupported`; qualified by `id_valid`.
- `ig_sel  output  3  select to imm_gen`.
- `ig_in  output  25  equals id_inst[31:7]`.
- `flush  input  1  discard all buffered and incoming instructions`.
- `perf_stall_cnt  output  32  stall cycle counter`; see Configuration.
- `perf_bubble_cnt  output  32  bubble cycle counter`; see Configuration.

## Operation
- **FIFO state:** `cnt` in {EMPTY=0, ONE=1, FULL=2}, with 1-bit read and write pointers.
- **Handshake events:**
  - push = `if_valid & if_ready`.
  - pop = `id_valid & id_ready`.
- **State transitions:**
  - push only: `cnt` +1.
  - pop only: `cnt` -1.
  - push and pop together: `cnt` unchanged, both pointers advance.
- **Upstream ready:** `if_ready = rst_n & (cnt != FULL)`. It depends only on state, so there is no combinational path from `id_ready`.
- **Downstream valid:** `id_valid = (cnt != EMPTY) & ~flush`. `id_inst`/`id_pc` come from the head entry and are don't-care when `id_valid=0`.
- **Opcode classification** (`id_inst[6:0]`):
  - 0010011, 0000011, 1100111 → `IG_I_TYPE`.
  - 0100011 → `IG_S_TYPE`.
  - 1100011 → `IG_B_TYPE`.
  - 1101111 → `IG_J_TYPE`.
  - 0110111, 0010111 → `IG_U_TYPE`.
  - 0110011, 0001111, 1110011 → `IG_DISABLED`, legal.
  - All other opcodes → `IG_DISABLED`, `id_illegal=1`.
- **Hold rule:** registered flag `held <= id_valid & ~id_ready`. While `held=1`, `ig_sel = IG_DISABLED` regardless of opcode. The imm_gen then outputs last cycle's immediate, which belongs to the same head. If `id_valid=0`, `ig_sel = IG_DISABLED`.
- **Flush:**
  - Next state is `cnt=0`, pointers=0, `held=0`.
  - A push in the same cycle is discarded.
  - A pop in the same cycle does not occur, because `id_valid` is forced 0.
- **Reset (async, `rst_n` low):**
  - `cnt=0`, pointers=0, `held=0`.
  - `id_valid=0`, `if_ready=0`, `ig_sel=IG_DISABLED`.
  - Perf counters cleared.
  - Buffer data is not reset.
- **Reset mid-operation:** buffered entries are lost. No entry is output after reset.

## Timing
- Latency is 1 cycle. A push at edge N with FIFO empty gives `id_valid=1` in cycle N+1.
- Throughput is 1 instruction/cycle with `id_ready` held high.
- If `id_ready` is low for 2+ cycles, `if_ready` falls in the cycle after the FIFO reaches FULL. Order is preserved.
- `ig_sel`/`ig_in` are combinational from head state and `held`. The imm_gen immediate is valid in the same cycle as `id_valid`.
- First cycle after `rst_n` deasserts: `if_ready=1`.

## Configuration
- Macro: `AMA_RISCV_DEC_CTRL_PERF_EN`.
- **Defined:**
  - `perf_stall_cnt` increments on each cycle with `id_valid & ~id_ready`.
  - `perf_bubble_cnt` increments on each cycle with `~id_valid & ~flush` after reset.
  - Both counters wrap at 2^32 and clear only on reset.
- **Undefined:** both ports exist but are tied to 0, and no counter flops are generated.

## Test plan
- **Reset:** FIFO FULL, then `rst_n` low mid-cycle → immediately `id_valid=0`, `if_ready=0`. After release: `cnt=0`, counters 0, and no stale entry appears.
- **Back-to-back stream:** push 0x00500093, 0x0020A223 (sw), 0x00208463 (beq), 0x0080006F (jal), 0x000010B7 (lui) with `id_ready=1` → each is presented one cycle after its push. `ig_sel` is I, S, B, J, U on consecutive cycles, and `ig_in = inst[31:7]`.
- **Stall:** head 0x00500093 with `id_ready=0` for 3 cycles while fetch pushes → `ig_sel=IG_I_TYPE` in cycle 1 and `IG_DISABLED` in cycles 2-3. `if_ready` goes low once FULL. On release, instructions drain in push order.
- **Flush:** FIFO FULL with `flush=1` and `if_valid=1` together → `id_valid=0` that cycle. Next cycle `cnt=0`, `if_ready=1`, and the flushed-cycle instruction is never presented.
- **Illegal/R-type:** 0x0000007F → `id_illegal=1`, `ig_sel=IG_DISABLED`. 0x002081B3 (add) → `id_illegal=0`, `ig_sel=IG_DISABLED`.
- **Perf counters:** 4 stall cycles and 2 bubble cycles with the macro defined → `perf_stall_cnt=4`, `perf_bubble_cnt=2`. Macro undefined → both read 0.
